// File: rtl/fd_fetch_queue_pkg.sv
// ============================================================================
// fd_fetch_queue_pkg : shared constants for the fetch/decode queue.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fd_fetch_queue_pkg;

   localparam logic [31:0] PC_BASE  = 32'h0000_3000;
   localparam logic [31:0] PC_TOP   = 32'h0000_6FFC;
   localparam logic [4:0]  EXC_ADEL = 5'd4;
   localparam logic [4:0]  EXC_NONE = 5'd0;

   // Word-aligned and inside the instruction memory window.
   function automatic logic pc_is_legal(input logic [31:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= PC_BASE) && (pc <= PC_TOP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fd_pc_check.sv
// ============================================================================
// fd_pc_check : combinational fetch-address check, pc in / exccode out.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fd_pc_check
   import fd_fetch_queue_pkg::*;
(
   input  logic [31:0] pc,
   output logic [4:0]  exccode
);

   assign exccode = pc_is_legal(pc) ? EXC_NONE : EXC_ADEL;

endmodule

`default_nettype wire

// File: rtl/fd_fetch_queue.sv
// ============================================================================
// fd_fetch_queue : DEPTH-entry {pc, instr, exccode} queue between fetch and
// decode. Optional fetch address checking under FD_FETCH_EXC_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fd_fetch_queue
   import fd_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              f_pc,
   input  logic [31:0]              f_instr,
   input  logic                     f_valid,
   output logic                     f_we,
   input  logic                     flush,
   input  logic                     d_stall,
   output logic                     d_valid,
   output logic [31:0]              d_pc,
   output logic [31:0]              d_instr,
   output logic [4:0]               d_exccode,
   output logic [$clog2(DEPTH):0]   d_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   r_pc    [DEPTH];
   logic [31:0]   r_instr [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_wr_instr;

   // Fetch enable never looks at d_stall, so no stall path reaches the PC.
   assign w_full  = (r_count == CW'(DEPTH));
   assign f_we    = flush | ~w_full;
   assign w_push  = f_valid & f_we & ~flush;
   assign d_valid = (r_count != '0);
   assign w_pop   = d_valid & ~d_stall & ~flush;

`ifdef FD_FETCH_EXC_EN
   logic [4:0] r_exc [DEPTH];
   logic [4:0] w_wr_exc;

   fd_pc_check u_pc_check (
      .pc      (f_pc),
      .exccode (w_wr_exc)
   );

   assign w_wr_instr = (w_wr_exc != EXC_NONE) ? 32'h0000_0000 : f_instr;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_exc[i] <= EXC_NONE;
      end else if (w_push) begin
         r_exc[r_wr_ptr] <= w_wr_exc;
      end
   end

   assign d_exccode = d_valid ? r_exc[r_rd_ptr] : EXC_NONE;
`else
   assign w_wr_instr = f_instr;
   assign d_exccode  = EXC_NONE;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc[i]    <= '0;
            r_instr[i] <= '0;
         end
      end else if (w_push) begin
         r_pc[r_wr_ptr]    <= f_pc;
         r_instr[r_wr_ptr] <= w_wr_instr;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign d_pc    = d_valid ? r_pc[r_rd_ptr]    : PC_RESET;
   assign d_instr = d_valid ? r_instr[r_rd_ptr] : 32'h0000_0000;
   assign d_count = r_count;

endmodule

`default_nettype wire
